jk_seq_stream_sched: RTL

- Round-robin scheduler that shares one serial Mealy sequence-recognizer datapath (single input bit x, single output bit y) between two requesters.
- The granted requester supplies a W-bit word. The block clears the datapath, streams the word MSB-first onto x one bit per clk, and captures the Mealy y bit each cycle.
- It returns the captured y word, a count of asserted y bits and the owner ID, with a done pulse.
- It sits between the requester logic and the recognizer instance; the recognizer shares clk.

---
 rtl/jk_seq_stream_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jk_seq_stream_sched.sv
// Two-requester round-robin scheduler feeding one serial Mealy recognizer:
// streams the granted word MSB-first on fsm_x and captures fsm_y per bit.
module jk_seq_stream_sched #(
  parameter  int W  = 8,
  localparam int HW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [W-1:0]  data0,
  input  logic          req1,
  input  logic [W-1:0]  data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          fsm_x,
  output logic          fsm_rst_n,
  input  logic          fsm_y,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [HW-1:0] hits,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          win1;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [W-1:0]  cap_q, cap_d;
  logic [HW-1:0] cnt_q, cnt_d;

  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          x_q, x_d, rstn_q, rstn_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [W-1:0]  result_q, result_d;
  logic [HW-1:0] hits_q, hits_d;
  logic          owner_q, owner_d;

  function automatic logic [HW-1:0] popcount(input logic [W-1:0] v);
    logic [HW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + HW'(v[i]);
    return c;
  endfunction

  // Tie goes to whoever was not served last; last_q doubles as the owner tag.
  assign win1 = req1 & (~req0 | ~last_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      x_q      <= 1'b0;
      rstn_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      hits_q   <= '0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      x_q      <= x_d;
      rstn_q   <= rstn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      hits_q   <= hits_d;
      owner_q  <= owner_d;
    end
  end

  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
    cap_q  <= cap_d;
    cnt_q  <= cnt_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = CLEAR;
      CLEAR:   state_d = SHIFT;
      SHIFT:   if (cnt_q == HW'(W-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    sreg_d = sreg_q;
    cap_d  = cap_q;
    cnt_d  = cnt_q;
    if (state_q == IDLE && (req0 || req1)) begin
      last_d = win1;
      sreg_d = win1 ? data1 : data0;
      cap_d  = '0;
      cnt_d  = '0;
    end else if (state_q == SHIFT) begin
      sreg_d = {sreg_q[W-2:0], 1'b0};
      cap_d  = {cap_q[W-2:0], fsm_y};
      cnt_d  = cnt_q + HW'(1);
    end
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    gnt0_d   = (state_d == CLEAR) & ~last_d;
    gnt1_d   = (state_d == CLEAR) &  last_d;
    x_d      = (state_d == SHIFT) & sreg_d[W-1];
    rstn_d   = (state_d == SHIFT);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    result_d = result_q;
    hits_d   = hits_q;
    owner_d  = owner_q;
    if (state_d == DONE) begin
      result_d = cap_d;
      hits_d   = popcount(cap_d);
      owner_d  = last_q;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign fsm_x     = x_q;
  assign fsm_rst_n = rstn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign hits      = hits_q;
  assign owner     = owner_q;

endmodule
